pl_mem_wb: RTL and testbench

- Pipeline stage directly downstream of the EX stage.
- Consumes the EX pipeline register, operation result, destination address and data-memory addresses.
- Performs load/store transactions to data memory over a req/ack handshake, stalling upstream while a transaction is outstanding.
- Produces registered write-back strobes/data for the integer and RNS register files, plus the saved carry flag.

---
 rtl/pl_mem_wb.sv | 128 ++++++++++++
 tb/tb_pl_mem_wb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_mem_wb.sv
// MEM/WB stage: issues load/store over a req/ack handshake and stalls EX while a
// transaction is outstanding; drives registered write-back strobes and the carry flag.
module pl_mem_wb #(
  parameter int NUM_DOMAINS = 2,
  parameter int ADDR_WID    = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [0:7]                 EX_reg,
  input  logic [NUM_DOMAINS*8-1:0]   operation_result,
  input  logic [3:0]                 destination_reg_addr,
  input  logic [ADDR_WID-1:0]        data_wr_addr,
  input  logic [ADDR_WID-1:0]        data_rd_addr,
  input  logic                       carry_in,
  output logic                       stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WID-1:0]        mem_addr,
  output logic [7:0]                 mem_wdata,
  input  logic [7:0]                 mem_rdata,
  input  logic                       mem_ack,
  output logic                       wb_int_en,
  output logic                       wb_rns_en,
  output logic [2:0]                 wb_addr,
  output logic [NUM_DOMAINS*8-1:0]   wb_data,
  output logic                       carry_flag,
  output logic                       mem_err
);
  localparam int DW = NUM_DOMAINS * 8;

  typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD} state_t;

  state_t                state_q;
  logic [7:0]            tmo_q;
  logic                  req_q, we_q, wb_int_q, wb_rns_q, carry_q, err_q;
  logic [ADDR_WID-1:0]   addr_q;
  logic [7:0]            wdata_q;
  logic [2:0]            wb_addr_q;
  logic [DW-1:0]         wb_data_q;

  logic       valid;
  logic [7:0] tmo_inc;
  logic       unused_dest_rns;

  // destination_RNS in EX_reg is redundant with destination_reg_addr[3]
  assign unused_dest_rns = EX_reg[7];
  assign valid   = !(EX_reg[3] | EX_reg[5] | EX_reg[6]);
  assign tmo_inc = tmo_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_int_q  <= 1'b0;
      wb_rns_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wb_int_q <= 1'b0;
      wb_rns_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (valid) begin
            if (EX_reg[2]) carry_q <= carry_in;
            if (EX_reg[0]) begin
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= data_wr_addr;
              wdata_q <= operation_result[7:0];
              state_q <= WAIT_WR;
            end else if (EX_reg[4]) begin
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= data_rd_addr;
              state_q <= WAIT_RD;
            end else if (EX_reg[1]) begin
              wb_data_q <= operation_result;
              wb_addr_q <= destination_reg_addr[2:0];
              wb_rns_q  <= destination_reg_addr[3];
              wb_int_q  <= !destination_reg_addr[3];
            end
          end
        end
        WAIT_WR, WAIT_RD: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= IDLE;
            // loads always land in the integer file; dest held by stall
            if (state_q == WAIT_RD) begin
              wb_int_q  <= 1'b1;
              wb_addr_q <= destination_reg_addr[2:0];
              wb_data_q <= DW'(mem_rdata);
            end
          end else if (tmo_inc == 8'(TIMEOUT_CYC)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = (state_q != IDLE);
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign wb_int_en  = wb_int_q;
  assign wb_rns_en  = wb_rns_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign carry_flag = carry_q;
  assign mem_err    = err_q;
endmodule

// File: tb/tb_pl_mem_wb.sv
// Randomized scoreboard bench for pl_mem_wb: driver pushes expectations, a memory
// responder models ack latency, and a monitor pops/compares on DUT activity.
module tb_pl_mem_wb;
  localparam int ND = 2, AW = 16, TO = 15;

  typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; } mreq_t;
  typedef struct { logic rns; logic [2:0] addr; logic [15:0] data; } wb_t;
  typedef struct { bit noack; int d; } resp_t;

  logic clk = 1'b0, reset;
  logic [0:7] EX_reg;
  logic [15:0] operation_result, data_wr_addr, data_rd_addr, mem_addr, wb_data;
  logic [3:0] destination_reg_addr;
  logic carry_in, stall, mem_req, mem_we, mem_ack, wb_int_en, wb_rns_en, carry_flag, mem_err;
  logic [7:0] mem_wdata, mem_rdata;
  logic [2:0] wb_addr;

  pl_mem_wb #(.NUM_DOMAINS(ND), .ADDR_WID(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .EX_reg(EX_reg), .operation_result(operation_result),
    .destination_reg_addr(destination_reg_addr), .data_wr_addr(data_wr_addr),
    .data_rd_addr(data_rd_addr), .carry_in(carry_in), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_int_en(wb_int_en), .wb_rns_en(wb_rns_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .carry_flag(carry_flag), .mem_err(mem_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  mreq_t mq[$];
  wb_t   wq[$];
  resp_t rq[$];
  bit exp_carry = 0, exp_err = 0, mon_en = 0, prev_req = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_wdata = '0;
  int req_cycles = 0;
  int cfg_delay = -1;  // -1 random, -2 never ack, >=0 fixed
  bit cfg_rdata_fix = 0;
  logic [7:0] cfg_rdata = '0;
  bit busy = 0, noack = 0;
  int cnt = 0;

  localparam logic [0:7] NOP = 8'b0001_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // Behavioural model: each accepted instruction yields at most one memory request
  // or one write-back; loads' write-back is produced by the memory responder.
  task automatic issue(input logic [0:7] ex, input logic [15:0] res, input logic [3:0] dest,
                       input logic [15:0] wa, input logic [15:0] ra, input logic cin);
    int n = 0;
    bit valid;
    @(negedge clk);
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (stall) flag("stall_timeout: stall still high after 200 cycles, required low");
    EX_reg = ex; operation_result = res; destination_reg_addr = dest;
    data_wr_addr = wa; data_rd_addr = ra; carry_in = cin;
    valid = !(ex[3] || ex[5] || ex[6]);
    if (valid) begin
      if (ex[2]) exp_carry = cin;
      if (ex[0])      mq.push_back('{1'b1, wa, res[7:0]});
      else if (ex[4]) mq.push_back('{1'b0, ra, 8'h00});
      else if (ex[1]) wq.push_back('{dest[3], dest[2:0], res});
    end
  endtask

  task automatic issue_rand();
    logic [0:7] ex;
    ex = 8'($urandom);
    if ($urandom_range(3) != 0) begin ex[3] = 0; ex[5] = 0; ex[6] = 0; end
    issue(ex, 16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // Memory responder; also throws in spurious acks while no request is pending.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!mem_req) begin
      busy = 0;
      if ($urandom_range(7) == 0) begin mem_ack = 1'b1; mem_rdata = 8'($urandom); end
    end else begin
      if (!busy) begin
        busy = 1;
        if (cfg_delay == -2) begin noack = 1; cnt = 0; end
        else if (cfg_delay >= 0) begin noack = 0; cnt = cfg_delay; end
        else begin noack = ($urandom_range(15) == 0); cnt = $urandom_range(4); end
        rq.push_back('{noack, cnt});
      end
      if (!noack) begin
        if (cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = cfg_rdata_fix ? cfg_rdata : 8'($urandom);
          if (!mem_we) wq.push_back('{1'b0, destination_reg_addr[2:0], {8'h00, mem_rdata}});
          busy = 0;
        end else cnt--;
      end
    end
  end

  // Monitor
  always @(posedge clk) begin
    mreq_t m; wb_t w; resp_t r;
    #1;
    if (!mon_en) begin
      prev_req = mem_req;
      req_cycles = 0;
    end else begin
      if (mem_req && !prev_req) begin
        req_cycles = 0;
        if (mq.size() == 0) flag($sformatf("unexpected_req: got req we=%0d addr=%0h, required none", mem_we, mem_addr));
        else begin
          m = mq.pop_front();
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (mem_req) req_cycles++;
      if (!mem_req && prev_req) begin
        if (rq.size() == 0) flag("unexpected_req_end: request ended with no transaction recorded");
        else begin
          r = rq.pop_front();
          chk("req_cycles", req_cycles, r.noack ? TO : r.d + 1);
          if (r.noack) exp_err = 1;
        end
      end
      if (mem_req) begin
        last_addr = mem_addr;
        last_wdata = mem_wdata;
      end else begin
        chk("addr_hold", mem_addr, last_addr);
        chk("wdata_hold", mem_wdata, last_wdata);
      end
      chk("stall", stall, mem_req);
      if (wb_int_en || wb_rns_en) begin
        if (wq.size() == 0) flag($sformatf("unexpected_wb: got addr=%0d data=%0h, required none", wb_addr, wb_data));
        else begin
          w = wq.pop_front();
          chk("wb_rns_en", wb_rns_en, w.rns);
          chk("wb_int_en", wb_int_en, !w.rns);
          chk("wb_addr", wb_addr, w.addr);
          chk("wb_data", wb_data, w.data);
        end
      end
      chk("carry_flag", carry_flag, exp_carry);
      chk("mem_err", mem_err, exp_err);
      prev_req = mem_req;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_wb_int_en"}, wb_int_en, 0);
    chk({tag, "_wb_rns_en"}, wb_rns_en, 0);
    chk({tag, "_wb_addr"}, wb_addr, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_carry"}, carry_flag, 0);
    chk({tag, "_mem_err"}, mem_err, 0);
  endtask

  initial begin
    reset = 1'b0; EX_reg = NOP; operation_result = '0; destination_reg_addr = '0;
    data_wr_addr = '0; data_rd_addr = '0; carry_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1;

    // ALU write to integer file, then RNS write
    issue(8'b0100_0000, 16'h00A5, 4'b0011, 16'h0, 16'h0, 1'b0);
    issue(NOP, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);
    issue(8'b0100_0000, 16'h3F12, 4'b1010, 16'h0, 16'h0, 1'b0);
    issue(NOP, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);
    // store with 3 cycles of stall
    cfg_delay = 2;
    issue(8'b1000_0000, 16'h007E, 4'h0, 16'h0040, 16'h0, 1'b0);
    issue(NOP, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);
    // load acked on the earliest edge
    cfg_delay = 0; cfg_rdata_fix = 1; cfg_rdata = 8'h9C;
    issue(8'b0000_1000, 16'h0, 4'd5, 16'h0, 16'h0100, 1'b0);
    issue(NOP, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);
    cfg_rdata_fix = 0; cfg_delay = -1;
    // carry set, then an invalidated load that must not touch carry or memory
    issue(8'b0010_0000, 16'h0, 4'h0, 16'h0, 16'h0, 1'b1);
    issue(8'b0011_1000, 16'h0, 4'h1, 16'h0, 16'h0200, 1'b0);
    issue(8'b0011_1000, 16'h0, 4'h1, 16'h0, 16'h0200, 1'b0);
    // store has priority over load
    issue(8'b1000_1000, 16'h0055, 4'h2, 16'h1234, 16'h5678, 1'b0);
    issue(NOP, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);
    // load without ack times out and sets sticky error
    cfg_delay = -2;
    issue(8'b0100_1000, 16'h0, 4'd6, 16'h0, 16'h0300, 1'b0);
    issue(NOP, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);
    cfg_delay = -1;

    for (int i = 0; i < 300; i++) issue_rand();
    issue(NOP, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);

    // reset in the middle of WAIT_RD
    cfg_delay = -2;
    issue(8'b0000_1000, 16'h0, 4'd3, 16'h0, 16'h0400, 1'b0);
    repeat (3) @(negedge clk);
    mon_en = 0;
    reset = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    EX_reg = NOP;
    @(negedge clk);
    mq.delete(); wq.delete(); rq.delete();
    exp_carry = 0; exp_err = 0; last_addr = '0; last_wdata = '0;
    cfg_delay = -1;
    reset = 1'b1;
    mon_en = 1;
    for (int i = 0; i < 30; i++) issue_rand();
    issue(NOP, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);
    begin
      int n = 0;
      while (stall && n < 100) begin @(negedge clk); n++; end
    end
    repeat (4) @(negedge clk);
    chk("mq_drained", mq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
